// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width/constants, sequencer state encoding,
// and digit-level helpers (nine's complement, validity).
package bcd_pkg;

    localparam int unsigned BCD_W    = 4;
    localparam logic [3:0]  BCD_MAX  = 4'd9;
    localparam logic [3:0]  BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Nine's complement of a valid BCD digit.
    function automatic logic [3:0] nines_comp(input logic [3:0] d);
        return 4'(BCD_MAX - d);
    endfunction

    // A nibble is a legal BCD digit when it is 0..9.
    function automatic logic digit_valid(input logic [3:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal correction.
// Ports: a, b  - BCD digits (0..9)
//        cin   - incoming decimal carry
//        sum   - corrected BCD digit
//        cout  - outgoing decimal carry
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw;

    // Binary sum peaks at 19; anything above 9 wraps into the next decade.
    always_comb begin
        raw  = 5'(a) + 5'(b) + 5'(cin);
        sum  = raw[3:0];
        cout = 1'b0;
        if (raw > 5'(BCD_MAX)) begin
            sum  = 4'(raw[3:0] + BCD_CORR);
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub_ctrl.sv
// Serial packed-BCD add/subtract sequencer: one shared digit adder,
// least-significant digit first, one digit per clock.
// Ports: clk, rst            - clock, async active-high reset
//        start, op_sub       - request (sampled in IDLE), 0=A+B / 1=A-B
//        a_in, b_in          - packed BCD operands, digit 0 in [3:0]
//        busy, done          - in-progress level, one-cycle completion pulse
//        result              - packed BCD result (tens complement if borrow)
//        carry_out, borrow   - final carry, negative-result flag (sub only)
//        err                 - invalid digit in a captured operand
module bcd_serial_addsub_ctrl
    import bcd_pkg::*;
#(
    parameter int unsigned NDIG = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op_sub,
    input  logic [BCD_W*NDIG-1:0] a_in,
    input  logic [BCD_W*NDIG-1:0] b_in,
    output logic                  busy,
    output logic                  done,
    output logic [BCD_W*NDIG-1:0] result,
    output logic                  carry_out,
    output logic                  borrow,
    output logic                  err
);

    localparam int unsigned W     = BCD_W * NDIG;
    localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               sub_q, sub_d;
    logic [W-1:0]       a_q, a_d, b_q, b_d;
    logic [W-1:0]       result_d;
    logic               busy_d, done_d, carry_out_d, borrow_d, err_d;

    logic               ops_valid;
    logic               last_digit;
    logic [3:0]         a_dig, b_raw, b_dig, sum_dig;
    logic               cout_dig;

    // Both incoming operands must be all-BCD before the operation starts.
    always_comb begin
        ops_valid = 1'b1;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (!digit_valid(a_in[i*BCD_W +: BCD_W]) ||
                !digit_valid(b_in[i*BCD_W +: BCD_W]))
                ops_valid = 1'b0;
        end
    end

    // Current digit pair; subtraction adds the nine's complement of B.
    always_comb begin
        a_dig      = 4'(a_q >> (BCD_W * 32'(idx_q)));
        b_raw      = 4'(b_q >> (BCD_W * 32'(idx_q)));
        b_dig      = sub_q ? nines_comp(b_raw) : b_raw;
        last_digit = (idx_q == IDX_W'(NDIG - 1));
    end

    bcd_digit_add u_digit_add (
        .a    (a_dig),
        .b    (b_dig),
        .cin  (carry_q),
        .sum  (sum_dig),
        .cout (cout_dig)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ops_valid ? ST_ADD : ST_DONE;
            ST_ADD:  if (last_digit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values for datapath and registered outputs.
    always_comb begin
        idx_d       = idx_q;
        carry_d     = carry_q;
        sub_d       = sub_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result;
        carry_out_d = carry_out;
        borrow_d    = borrow;
        err_d       = err;
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d         = a_in;
                    b_d         = b_in;
                    sub_d       = op_sub;
                    carry_d     = op_sub;   // +1 completes the tens complement
                    idx_d       = '0;
                    err_d       = ~ops_valid;
                    carry_out_d = 1'b0;
                    borrow_d    = 1'b0;
                    if (!ops_valid) result_d = '0;
                end
            end
            ST_ADD: begin
                for (int i = 0; i < int'(NDIG); i++) begin
                    if (idx_q == IDX_W'(i)) result_d[i*BCD_W +: BCD_W] = sum_dig;
                end
                idx_d   = IDX_W'(idx_q + 1'b1);
                carry_d = cout_dig;
                if (last_digit) begin
                    carry_out_d = cout_dig;
                    borrow_d    = sub_q & ~cout_dig;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= '0;
            carry_q   <= 1'b0;
            sub_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            borrow    <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            sub_q     <= sub_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result    <= result_d;
            carry_out <= carry_out_d;
            borrow    <= borrow_d;
            err       <= err_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub_ctrl.sv
// Directed self-checking bench for bcd_serial_addsub_ctrl (NDIG=4).
module tb_bcd_serial_addsub_ctrl;

    localparam int unsigned NDIG = 4;
    localparam int unsigned W    = 4 * NDIG;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op_sub;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         borrow;
    logic         err;

    int checks = 0;
    int errors = 0;

    bcd_serial_addsub_ctrl #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_sub    (op_sub),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .borrow    (borrow),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch one operation and check latency plus all flags at done.
    // With repulse=1 a second start with other operands is driven mid-ADD.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic [W-1:0] exp_res, input logic exp_c,
                          input logic exp_b, input logic exp_e, input int exp_lat,
                          input logic repulse);
        int lat;
        @(negedge clk);
        a_in = a; b_in = b; op_sub = sub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a_in = 16'h7777; b_in = 16'h3333; op_sub = ~sub;   // operands captured at E0
        check({tag, " busy@E0"}, 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (repulse) start = (lat == 1);
        end
        start = 1'b0;
        check({tag, " latency"},   32'(lat),       32'(exp_lat));
        check({tag, " result"},    32'(result),    32'(exp_res));
        check({tag, " carry_out"}, 32'(carry_out), 32'(exp_c));
        check({tag, " borrow"},    32'(borrow),    32'(exp_b));
        check({tag, " err"},       32'(err),       32'(exp_e));
        @(posedge clk); #1;
        check({tag, " done_drop"}, 32'({busy, done}), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_sub = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outs", 32'({busy, done, carry_out, borrow, err}), 32'd0);
        check("reset result", 32'(result), 32'd0);
        @(negedge clk); rst = 1'b0;

        run_op("add 1234+5678", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, NDIG, 1'b0);
        run_op("add 9999+0001", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, NDIG, 1'b0);
        run_op("sub 5000-1234", 16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b1, 1'b0, 1'b0, NDIG, 1'b0);
        run_op("sub 1234-5000", 16'h1234, 16'h5000, 1'b1, 16'h6234, 1'b0, 1'b1, 1'b0, NDIG, 1'b0);
        run_op("sub 0042-0042", 16'h0042, 16'h0042, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, NDIG, 1'b0);

        // Held stable across idle cycles.
        repeat (3) @(posedge clk);
        #1;
        check("hold result", 32'(result), 32'h0000);
        check("hold flags", 32'({carry_out, borrow, err}), 32'b100);

        run_op("invalid a", 16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        run_op("invalid b", 16'h0001, 16'hF000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        run_op("add 0001+0001", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, NDIG, 1'b0);
        run_op("repulse", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, NDIG, 1'b1);

        // Asynchronous reset in the middle of digit processing.
        @(negedge clk);
        a_in = 16'h4321; b_in = 16'h1111; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid partial", 32'(result[7:0]), 32'h32);
        #2 rst = 1'b1;
        #1;
        check("async rst outs", 32'({busy, done, carry_out, borrow, err}), 32'd0);
        check("async rst result", 32'(result), 32'd0);
        @(negedge clk); rst = 1'b0;
        run_op("after rst", 16'h0456, 16'h0544, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, NDIG, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
